// File: rtl/fifo_pkg.sv
// Shared definitions for the circular delay buffer (fifo) and its read-side
// drain controller (fifo_drain): default geometry and the drain FSM states.
package fifo_pkg;

    localparam int DEPTH_DEFAULT = 8;
    localparam int BITS_DEFAULT  = 64;

    typedef enum logic [2:0] {
        IDLE,
        CAPT,
        PRES,
        ADV,
        DONE
    } drain_state_t;

endpackage

// File: rtl/fifo.sv
// DEPTH-entry circular delay buffer. q always shows the slot under the
// pointer (the oldest entry); each en pulse overwrites that slot with d and
// steps the pointer, so DEPTH pulses walk the whole ring back to the start.
module fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int BITS  = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);

    localparam int AW = $clog2(DEPTH);

    logic [BITS-1:0] mem [DEPTH];
    logic [AW-1:0]   ptr;

    // Ring storage and pointer; the pointer wraps for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            // NOTE: the ring is cleared on reset on purpose: a reset during a drain
            // must leave no stale entries behind, so every slot returns to zero.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[ptr] <= d;
            ptr      <= ptr + 1'b1;
        end
    end

    assign q = mem[ptr];

endmodule

// File: rtl/fifo_drain.sv
// Read-side controller for the circular delay buffer. A start pulse steps the
// buffer DEPTH times, presenting each oldest entry over a valid/ready port.
// Build option: FIFO_DRAIN_RECIRC_EN writes each entry back as it is read, so
// a full drain leaves the buffer unchanged; without it the drain zero-fills.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int BITS  = BITS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     fifo_en,
    output logic [BITS-1:0]          fifo_d,
    input  logic [BITS-1:0]          fifo_q,
    output logic [BITS-1:0]          out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH)-1:0] out_idx,
    output logic                     out_last
);

    localparam int             IW       = $clog2(DEPTH);
    localparam logic [IW-1:0]  LAST_IDX = IW'(DEPTH - 1);

    drain_state_t    state;
    logic [IW-1:0]   idx;
    logic [BITS-1:0] wb_data;

`ifdef FIFO_DRAIN_RECIRC_EN
    // Write the entry being advanced past straight back into its slot.
    assign wb_data = fifo_q;
`else
    // Advanced-past slots are overwritten with zero.
    assign wb_data = '0;
`endif

    // Drain FSM with the index counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fifo_en   <= 1'b0;
            fifo_d    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle with non-blocking
            // assignments; the case below raises them for exactly one cycle.
            done    <= 1'b0;
            fifo_en <= 1'b0;
            fifo_d  <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    // The pointer moved during the previous ADV, so fifo_q is the next entry.
                    out_data  <= fifo_q;
                    out_idx   <= idx;
                    out_valid <= 1'b1;
                    out_last  <= (idx == LAST_IDX);
                    state     <= PRES;
                end
                PRES: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        fifo_en   <= 1'b1;
                        fifo_d    <= wb_data;
                        state     <= ADV;
                    end
                end
                ADV: begin
                    if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= CAPT;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain attached to a fifo instance. The expected drain
// contents come from a queue model of the ring: each read takes the oldest
// value and rotates either the same value (recirculating build) or zero back in.
module tb_fifo_drain;

    localparam int DEPTH = 8;
    localparam int BITS  = 64;
    localparam int IW    = $clog2(DEPTH);

`ifdef FIFO_DRAIN_RECIRC_EN
    localparam bit RECIRC = 1'b1;
`else
    localparam bit RECIRC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            busy;
    logic            done;
    logic            drain_en;
    logic [BITS-1:0] drain_d;
    logic [BITS-1:0] fifo_q;
    logic [BITS-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_idx;
    logic            out_last;

    // Bench-side loading port, muxed onto the fifo while tb_load is high.
    logic            tb_load;
    logic            tb_en;
    logic [BITS-1:0] tb_d;

    fifo #(.DEPTH(DEPTH), .BITS(BITS)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tb_load ? tb_en : drain_en),
        .d     (tb_load ? tb_d  : drain_d),
        .q     (fifo_q)
    );

    fifo_drain #(.DEPTH(DEPTH), .BITS(BITS)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fifo_en   (drain_en),
        .fifo_d    (drain_d),
        .fifo_q    (fifo_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation records, written only by the monitor.
    logic [BITS-1:0] got_data [$];
    int              got_idx  [$];
    int              got_last [$];
    int              got_cyc  [$];
    int              done_cyc_q [$];
    int              done_cnt  = 0;
    int              en_cnt    = 0;
    int              valid_cnt = 0;
    int              hold_viol = 0;
    int              last_viol = 0;
    logic            hold_prev = 1'b0;
    logic [BITS-1:0] prev_data = '0;
    logic [IW-1:0]   prev_idx  = '0;

    // Monitor: sample everything mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev && (!out_valid || out_data !== prev_data || out_idx !== prev_idx))
                hold_viol <= hold_viol + 1;
            hold_prev <= out_valid && !out_ready;
            prev_data <= out_data;
            prev_idx  <= out_idx;
            if (out_last !== (out_valid && int'(out_idx) == DEPTH - 1))
                last_viol <= last_viol + 1;
            if (out_valid)
                valid_cnt <= valid_cnt + 1;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_idx.push_back(int'(out_idx));
                got_last.push_back(int'(out_last));
                got_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc_q.push_back(cyc);
            end
            if (drain_en)
                en_cnt <= en_cnt + 1;
        end else begin
            hold_prev <= 1'b0;
        end
    end

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [BITS-1:0] model [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write DEPTH values through the fifo's own port: kind 0 loads 1..DEPTH, kind 1 random.
    task automatic load(input int kind);
        logic [BITS-1:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = (kind == 0) ? BITS'(i + 1) : {$urandom, $urandom};
            @(posedge clk); #1;
            tb_load = 1'b1;
            tb_en   = 1'b1;
            tb_d    = v;
            model.push_back(v);
            void'(model.pop_front());
        end
        @(posedge clk); #1;
        tb_load = 1'b0;
        tb_en   = 1'b0;
        tb_d    = '0;
    endtask

    function automatic logic ready_for(input int mode, input int k);
        logic [3:0] pat;
        pat = 4'b1001;
        case (mode)
            0:       return 1'b1;
            1:       return pat[3 - (k % 4)];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One drain: mode 0 ready always high, 1 the 1-0-0-1 pattern, 2 random ready.
    task automatic drain(input string tag, input int mode, input bit extra_start);
        logic [BITS-1:0] exp [$];
        logic [BITS-1:0] v;
        int base, dq0, en0, d0, s_cyc;
        bit timed_out;
        for (int i = 0; i < DEPTH; i++) begin
            v = model.pop_front();
            exp.push_back(v);
            model.push_back(RECIRC ? v : '0);
        end
        @(posedge clk); #1;
        base = got_data.size();
        dq0  = done_cyc_q.size();
        en0  = en_cnt;
        d0   = done_cnt;
        start     = 1'b1;
        out_ready = ready_for(mode, 0);
        s_cyc     = cyc;
        timed_out = 1'b1;
        for (int k = 1; k < 400; k++) begin
            @(posedge clk); #1;
            start     = extra_start && (k == 5);
            out_ready = ready_for(mode, k);
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check({tag, " timeout"}, 64'(timed_out), 64'(0));
        check({tag, " done pulses"}, 64'(done_cnt - d0), 64'(1));
        check({tag, " fifo_en pulses"}, 64'(en_cnt - en0), 64'(DEPTH));
        check({tag, " elements"}, 64'(got_data.size() - base), 64'(DEPTH));
        check({tag, " busy after"}, 64'(busy), 64'(0));
        for (int i = 0; i < DEPTH; i++) begin
            if (base + i < got_data.size()) begin
                check($sformatf("%s data[%0d]", tag, i), got_data[base + i], exp[i]);
                check($sformatf("%s idx[%0d]", tag, i), 64'(got_idx[base + i]), 64'(i));
                check($sformatf("%s last[%0d]", tag, i), 64'(got_last[base + i]),
                      64'(i == DEPTH - 1));
            end else begin
                check($sformatf("%s missing[%0d]", tag, i), 64'(base + i), 64'(got_data.size()));
            end
        end
        if (mode == 0 && base < got_cyc.size() && dq0 < done_cyc_q.size()) begin
            check({tag, " first valid cycle"}, 64'(got_cyc[base] - s_cyc), 64'(2));
            check({tag, " done cycle"}, 64'(done_cyc_q[dq0] - s_cyc), 64'(3 * DEPTH + 1));
        end
        check({tag, " hold violations"}, 64'(hold_viol), 64'(0));
        check({tag, " out_last violations"}, 64'(last_viol), 64'(0));
    endtask

    initial begin
        int en0, v0, d0;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        tb_load   = 1'b0;
        tb_en     = 1'b0;
        tb_d      = '0;
        for (int i = 0; i < DEPTH; i++) model.push_back('0);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst fifo_en", 64'(drain_en), 64'(0));
        check("rst fifo_d", drain_d, 64'(0));
        check("rst out_data", out_data, 64'(0));
        check("rst out_valid", 64'(out_valid), 64'(0));
        check("rst out_idx", 64'(out_idx), 64'(0));
        check("rst out_last", 64'(out_last), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Ordered drain with ready held high, then a second drain with a stalling consumer.
        load(0);
        drain("seq", 0, 1'b0);
        drain("second", 1, 1'b0);

        // Fresh load drained under the 1-0-0-1 ready pattern.
        load(0);
        drain("pattern", 1, 1'b0);

        // A start pulse inside a drain must be ignored.
        load(0);
        drain("restart", 0, 1'b1);

        // Random contents and random back-pressure, drained twice.
        load(1);
        drain("rand1", 2, 1'b0);
        drain("rand2", 2, 1'b0);

        // Reset in the middle of a stalled presentation.
        load(0);
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            out_ready = (k < 8);
        end
        #3 rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'(0));
        check("midrst busy", 64'(busy), 64'(0));
        check("midrst fifo_en", 64'(drain_en), 64'(0));
        check("midrst done", 64'(done), 64'(0));
        check("midrst out_data", out_data, 64'(0));
        check("midrst out_idx", 64'(out_idx), 64'(0));
        check("midrst fifo_q", fifo_q, 64'(0));
        model.delete();
        for (int i = 0; i < DEPTH; i++) model.push_back('0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b0;
        drain("after reset", 0, 1'b0);

        // Idle with a willing consumer and no start.
        en0 = en_cnt;
        v0  = valid_cnt;
        d0  = done_cnt;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle fifo_en", 64'(en_cnt - en0), 64'(0));
        check("idle out_valid", 64'(valid_cnt - v0), 64'(0));
        check("idle done", 64'(done_cnt - d0), 64'(0));
        check("idle busy", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
